// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer: multi-cycle fetch/decode/memory control FSM for an 8-bit accumulator CPU
module cpu_ctrl_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              acc_zero,
  output logic              acc_we,
  output logic [1:0]        alu_op,
  output logic              out_we,
  output logic [7:0]        ir,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, MEM = 3'd3,
                            HALT = 3'd4, FAULT = 3'd5} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            st;
  logic [CW-1:0]     cnt;
  logic [3:0]        op;
  logic [ADDR_W-1:0] daddr;
  logic              mem_load;
  assign op       = ir[7:4];
  assign daddr    = ADDR_W'(ir[3:0]);
  assign mem_load = op == 4'h2 || op == 4'h3 || op == 4'h4;
  // cnt stays zero outside a waiting access, so every FETCH/MEM entry starts from zero
  always_ff @(posedge clk)
    if (rst) begin
      st  <= IDLE;
      pc  <= '0;
      ir  <= '0;
      cnt <= '0;
    end else if (ena) begin
      cnt <= '0;
      case (st)
        IDLE, HALT: if (start) st <= FETCH;
        FETCH:
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
            st <= DECODE;
          end else if (cnt == CW'(TIMEOUT - 1)) st <= FAULT;
          else cnt <= cnt + CW'(1);
        DECODE:
          case (op)
            4'h2, 4'h3, 4'h4, 4'h5: st <= MEM;
            4'h6: begin
              pc <= daddr;
              st <= FETCH;
            end
            4'h7: begin
              if (acc_zero) pc <= daddr;
              st <= FETCH;
            end
            4'hF: st <= HALT;
            default: st <= FETCH;
          endcase
        MEM:
          if (mem_ack) st <= FETCH;
          else if (cnt == CW'(TIMEOUT - 1)) st <= FAULT;
          else cnt <= cnt + CW'(1);
        FAULT: st <= FAULT;
        default: st <= IDLE;
      endcase
    end
  always_comb begin
    mem_req  = st == FETCH || st == MEM;
    mem_we   = st == MEM && op == 4'h5;
    mem_addr = st == MEM ? daddr : st == FETCH ? pc : '0;
    acc_we   = ena && ((st == DECODE && op == 4'h1) || (st == MEM && mem_ack && mem_load));
    alu_op   = st == DECODE && op == 4'h1 ? 2'b11 :
               st == MEM && op == 4'h2 ? 2'b01 :
               st == MEM && op == 4'h3 ? 2'b10 : 2'b00;
    out_we   = ena && st == DECODE && op == 4'h8;
    halted   = st == HALT || st == FAULT;
    fault    = st == FAULT;
    state    = st;
  end
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// tb_cpu_ctrl_sequencer: directed scenario tests against a small responding memory model
module tb_cpu_ctrl_sequencer;
  logic       clk = 0, rst = 1, ena = 1, start = 0, acc_zero = 0;
  logic       mem_req, mem_we, mem_ack, acc_we, out_we, halted, fault;
  logic [7:0] mem_addr, mem_rdata, ir, pc;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [7:0] mem [256];
  bit         auto_ack = 0;
  int         ack_delay = 0, wait_cnt = 0, passed = 0, total = 0;

  cpu_ctrl_sequencer #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .acc_zero(acc_zero),
    .acc_we(acc_we), .alu_op(alu_op), .out_we(out_we), .ir(ir), .pc(pc), .halted(halted),
    .fault(fault), .state(state));

  always #5 clk = ~clk;

  // memory answers after ack_delay waiting cycles; the delay count freezes with ena
  assign mem_ack   = auto_ack && mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (rst) wait_cnt <= 0;
    else if (ena) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    auto_ack = 0;
    do_reset();
    total++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
    total++; if (mem_req !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) $display("FAIL reset_outs got req=%b halt=%b fault=%b want 0", mem_req, halted, fault); else passed++;
    total++; if (pc !== 8'h00 || ir !== 8'h00) $display("FAIL reset_regs got pc=%h ir=%h want 00", pc, ir); else passed++;
    go();
    tick(2);
    total++; if (state !== 3'd1 || mem_req !== 1'b1) $display("FAIL fetch_wait got st=%0d req=%b want 1/1", state, mem_req); else passed++;
    do_reset();
    total++; if (state !== 3'd0 || mem_req !== 1'b0 || halted !== 1'b0) $display("FAIL midreset got st=%0d req=%b halt=%b want 0", state, mem_req, halted); else passed++;
    total++; if (pc !== 8'h00 || ir !== 8'h00) $display("FAIL midreset_regs got pc=%h ir=%h want 00", pc, ir); else passed++;
    go();
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) $display("FAIL restart got req=%b addr=%h we=%b want 1/00/0", mem_req, mem_addr, mem_we); else passed++;
    do_reset();
  endtask

  task automatic test_program();
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h80; mem[2] = 8'hF0;
    auto_ack = 1; ack_delay = 0;
    go();
    for (int c = 1; c <= 7; c++) begin
      total++; if (acc_we !== (c == 2)) $display("FAIL prog_acc_we c%0d got %b want %b", c, acc_we, c == 2); else passed++;
      total++; if (out_we !== (c == 4)) $display("FAIL prog_out_we c%0d got %b want %b", c, out_we, c == 4); else passed++;
      total++; if (halted !== (c >= 7)) $display("FAIL prog_halted c%0d got %b want %b", c, halted, c >= 7); else passed++;
      if (c == 2) begin
        total++; if (alu_op !== 2'b11) $display("FAIL prog_ldi_op got %b want 11", alu_op); else passed++;
      end
      if (c >= 6) begin
        total++; if (pc !== 8'h03) $display("FAIL prog_pc c%0d got %h want 03", c, pc); else passed++;
      end
      if (c < 7) tick();
    end
    total++; if (state !== 3'd4 || mem_req !== 1'b0) $display("FAIL halt_state got st=%0d req=%b want 4/0", state, mem_req); else passed++;
    go();
    total++; if (state !== 3'd1 || mem_addr !== 8'h03) $display("FAIL halt_resume got st=%0d addr=%h want 1/03", state, mem_addr); else passed++;
    do_reset();
  endtask

  task automatic test_mem_ops();
    clear_mem();
    mem[0] = 8'h23; mem[1] = 8'h57; mem[2] = 8'hF0;
    auto_ack = 1; ack_delay = 3;
    go();
    tick(4);
    total++; if (state !== 3'd2 || mem_req !== 1'b0) $display("FAIL add_decode got st=%0d req=%b want 2/0", state, mem_req); else passed++;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 8'h03 || mem_we !== 1'b0) $display("FAIL add_req k%0d got req=%b addr=%h we=%b want 1/03/0", k, mem_req, mem_addr, mem_we); else passed++;
      total++; if (acc_we !== (k == 3)) $display("FAIL add_acc_we k%0d got %b want %b", k, acc_we, k == 3); else passed++;
      if (k == 3) begin
        total++; if (alu_op !== 2'b01) $display("FAIL add_op got %b want 01", alu_op); else passed++;
      end
      tick();
    end
    total++; if (state !== 3'd1 || mem_addr !== 8'h01) $display("FAIL add_done got st=%0d addr=%h want 1/01", state, mem_addr); else passed++;
    tick(5);
    for (int k = 0; k < 4; k++) begin
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h07 || acc_we !== 1'b0) $display("FAIL st_req k%0d got req=%b we=%b addr=%h acc=%b want 1/1/07/0", k, mem_req, mem_we, mem_addr, acc_we); else passed++;
      tick();
    end
    total++; if (state !== 3'd1 || fault !== 1'b0) $display("FAIL st_done got st=%0d fault=%b want 1/0", state, fault); else passed++;
    do_reset();
  endtask

  task automatic test_jumps();
    int n;
    clear_mem();
    mem[0] = 8'h7A; mem[8'h0A] = 8'h7C; mem[8'h0B] = 8'h6F; mem[8'hFF] = 8'h65;
    auto_ack = 1; ack_delay = 0; acc_zero = 1;
    go();
    tick(2);
    total++; if (pc !== 8'h0A || mem_addr !== 8'h0A) $display("FAIL jz_taken got pc=%h addr=%h want 0a", pc, mem_addr); else passed++;
    acc_zero = 0;
    tick(2);
    total++; if (pc !== 8'h0B || mem_addr !== 8'h0B) $display("FAIL jz_not_taken got pc=%h addr=%h want 0b", pc, mem_addr); else passed++;
    n = 0;
    while (!(state == 3'd1 && mem_addr == 8'hFF) && n < 1000) begin
      tick();
      n++;
    end
    total++; if (n >= 1000) $display("FAIL reach_ff got timeout after %0d cycles want fetch at ff", n); else passed++;
    tick();
    total++; if (pc !== 8'h00 || ir !== 8'h65) $display("FAIL pc_wrap got pc=%h ir=%h want 00/65", pc, ir); else passed++;
    tick();
    total++; if (pc !== 8'h05 || mem_addr !== 8'h05) $display("FAIL jmp_target got pc=%h addr=%h want 05", pc, mem_addr); else passed++;
    do_reset();
  endtask

  task automatic test_timeout();
    clear_mem();
    auto_ack = 0;
    go();
    tick(3);
    total++; if (state !== 3'd1 || fault !== 1'b0) $display("FAIL to_wait got st=%0d fault=%b want 1/0", state, fault); else passed++;
    tick();
    total++; if (state !== 3'd5 || fault !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) $display("FAIL to_fault got st=%0d f=%b h=%b req=%b want 5/1/1/0", state, fault, halted, mem_req); else passed++;
    go();
    total++; if (state !== 3'd5) $display("FAIL fault_start got st=%0d want 5", state); else passed++;
    do_reset();
    total++; if (state !== 3'd0 || fault !== 1'b0) $display("FAIL fault_rst got st=%0d fault=%b want 0/0", state, fault); else passed++;
    auto_ack = 1; ack_delay = 3;
    go();
    tick(3);
    total++; if (mem_ack !== 1'b1 || state !== 3'd1) $display("FAIL ack4_cycle got ack=%b st=%0d want 1/1", mem_ack, state); else passed++;
    tick();
    total++; if (state !== 3'd2 || fault !== 1'b0) $display("FAIL ack4_wins got st=%0d fault=%b want 2/0", state, fault); else passed++;
    do_reset();
  endtask

  task automatic test_ena();
    clear_mem();
    mem[0] = 8'h42;
    auto_ack = 1; ack_delay = 0;
    go();
    tick();
    auto_ack = 0;
    tick(2);
    ena = 0;
    tick(10);
    total++; if (state !== 3'd3 || pc !== 8'h01 || ir !== 8'h42 || fault !== 1'b0) $display("FAIL ena_frozen got st=%0d pc=%h ir=%h f=%b want 3/01/42/0", state, pc, ir, fault); else passed++;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) $display("FAIL ena_outs got req=%b addr=%h want 1/02", mem_req, mem_addr); else passed++;
    auto_ack = 1;
    #1;
    total++; if (acc_we !== 1'b0) $display("FAIL ena_strobe got %b want 0", acc_we); else passed++;
    auto_ack = 0;
    ena = 1;
    tick(2);
    total++; if (state !== 3'd3 || fault !== 1'b0) $display("FAIL ena_resume got st=%0d fault=%b want 3/0", state, fault); else passed++;
    auto_ack = 1;
    #1;
    total++; if (acc_we !== 1'b1 || alu_op !== 2'b00) $display("FAIL ld_ack got acc=%b op=%b want 1/00", acc_we, alu_op); else passed++;
    tick();
    total++; if (state !== 3'd1 || mem_addr !== 8'h01) $display("FAIL ld_done got st=%0d addr=%h want 1/01", state, mem_addr); else passed++;
    do_reset();
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program();
    test_mem_ops();
    test_jumps();
    test_timeout();
    test_ena();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
